// File: rtl/m68k_bus_arbiter.sv
// rtl/m68k_bus_arbiter.sv - BR_n/BG_n/BGACK_n 68000 bus arbiter (optional macro ARB_TIMEOUT_EN)
module m68k_bus_arbiter #(
    parameter int SYNC_STAGES      = 3,
    parameter int GRANT_TIMEOUT    = 16,
    parameter int DRAIN_IDLE_EDGES = 2
) (
    input  logic c200m,
    input  logic reset_n,
    input  logic m68k_clk,
    input  logic br_n,
    input  logic bgack_n,
    input  logic txn_active,
    output logic txn_hold,
    output logic bg_n,
    output logic bus_release,
    output logic dma_active,
    output logic timeout_err,
    input  logic err_clr
);

    localparam int IDLE_W = $clog2(DRAIN_IDLE_EDGES + 1);

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        GRANT,
        OWNED,
        RECOVER
    } state_t;

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] br_sync;
    logic [SYNC_STAGES-1:0] bgack_sync;
    logic                   c7m_fall;
    logic                   br_s;
    logic                   bgack_s;

    state_t              state, state_d;
    logic [IDLE_W-1:0]   idle_cnt, idle_cnt_d;
    logic                hold_d, bg_d, rel_d, dma_d;
    logic                tmo_set;

`ifdef ARB_TIMEOUT_EN
    logic [7:0]          tmo_cnt, tmo_cnt_d;
`endif

    // Synchronise the asynchronous bus-side inputs into the Pi clock domain
    always_ff @(posedge c200m or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync   <= '0;
            br_sync    <= '1;
            bgack_sync <= '1;
        end else begin
            clk_sync   <= {clk_sync[SYNC_STAGES-2:0], m68k_clk};
            br_sync    <= {br_sync[SYNC_STAGES-2:0], br_n};
            bgack_sync <= {bgack_sync[SYNC_STAGES-2:0], bgack_n};
        end
    end

    assign c7m_fall = clk_sync[SYNC_STAGES-1] & ~clk_sync[SYNC_STAGES-2];
    assign br_s     = br_sync[SYNC_STAGES-1];
    assign bgack_s  = bgack_sync[SYNC_STAGES-1];

    // Next-state and next-output logic; everything advances only on a c7m falling edge
    always_comb begin
        state_d    = state;
        idle_cnt_d = idle_cnt;
        hold_d     = txn_hold;
        bg_d       = bg_n;
        rel_d      = bus_release;
        dma_d      = dma_active;
        tmo_set    = 1'b0;
`ifdef ARB_TIMEOUT_EN
        tmo_cnt_d  = (state == GRANT) ? tmo_cnt : 8'd0;
`endif
        if (c7m_fall) begin
            case (state)
                IDLE: begin
                    if (!br_s) begin
                        state_d    = DRAIN;
                        hold_d     = 1'b1;
                        idle_cnt_d = '0;
                    end
                end
                DRAIN: begin
                    if (br_s) begin
                        state_d    = IDLE;
                        hold_d     = 1'b0;
                        idle_cnt_d = '0;
                    end else if (txn_active) begin
                        idle_cnt_d = '0;
                    end else if (32'(idle_cnt) + 32'd1 >= 32'(DRAIN_IDLE_EDGES)) begin
                        state_d    = GRANT;
                        bg_d       = 1'b0;
                        rel_d      = 1'b1;
                        idle_cnt_d = '0;
                    end else begin
                        idle_cnt_d = idle_cnt + 1'b1;
                    end
                end
                GRANT: begin
                    // An acknowledge beats a simultaneous withdrawal
                    if (!bgack_s) begin
                        state_d = OWNED;
                        bg_d    = 1'b1;
                        dma_d   = 1'b1;
                    end else if (br_s) begin
                        state_d = IDLE;
                        bg_d    = 1'b1;
                        rel_d   = 1'b0;
                        hold_d  = 1'b0;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (32'(tmo_cnt) + 32'd1 >= 32'(GRANT_TIMEOUT)) begin
                        state_d = IDLE;
                        bg_d    = 1'b1;
                        rel_d   = 1'b0;
                        hold_d  = 1'b0;
                        tmo_set = 1'b1;
                    end else begin
                        tmo_cnt_d = tmo_cnt + 8'd1;
                    end
`endif
                end
                OWNED: begin
                    hold_d = 1'b1;
                    rel_d  = 1'b1;
                    dma_d  = 1'b1;
                    if (bgack_s) begin
                        state_d = RECOVER;
                        dma_d   = 1'b0;
                    end
                end
                RECOVER: begin
                    // Sequencer is still held, so a fresh request skips the drain
                    if (!br_s) begin
                        state_d = GRANT;
                        bg_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        rel_d   = 1'b0;
                        hold_d  = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    hold_d  = 1'b0;
                    bg_d    = 1'b1;
                    rel_d   = 1'b0;
                    dma_d   = 1'b0;
                end
            endcase
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge c200m or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            idle_cnt    <= '0;
            txn_hold    <= 1'b0;
            bg_n        <= 1'b1;
            bus_release <= 1'b0;
            dma_active  <= 1'b0;
        end else begin
            state       <= state_d;
            idle_cnt    <= idle_cnt_d;
            txn_hold    <= hold_d;
            bg_n        <= bg_d;
            bus_release <= rel_d;
            dma_active  <= dma_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Grant timeout counter
    always_ff @(posedge c200m or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt <= 8'd0;
        end else begin
            tmo_cnt <= tmo_cnt_d;
        end
    end
`endif

    // Sticky timeout flag; a clear wins over a simultaneous set
    always_ff @(posedge c200m or negedge reset_n) begin
        if (!reset_n) begin
            timeout_err <= 1'b0;
        end else if (err_clr) begin
            timeout_err <= 1'b0;
        end else if (tmo_set) begin
            timeout_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_m68k_bus_arbiter.sv
// tb/tb_m68k_bus_arbiter.sv - directed vector bench for m68k_bus_arbiter
`timescale 1ns/100ps
module tb_m68k_bus_arbiter;

    logic c200m = 1'b0;
    logic reset_n = 1'b0;
    logic m68k_clk = 1'b0;
    logic br_n = 1'b1;
    logic bgack_n = 1'b1;
    logic txn_active = 1'b0;
    logic err_clr = 1'b0;
    logic txn_hold, bg_n, bus_release, dma_active, timeout_err;

    int checks = 0;
    int errors = 0;

    m68k_bus_arbiter #(
        .SYNC_STAGES(3),
        .GRANT_TIMEOUT(16),
        .DRAIN_IDLE_EDGES(2)
    ) dut (
        .c200m(c200m),
        .reset_n(reset_n),
        .m68k_clk(m68k_clk),
        .br_n(br_n),
        .bgack_n(bgack_n),
        .txn_active(txn_active),
        .txn_hold(txn_hold),
        .bg_n(bg_n),
        .bus_release(bus_release),
        .dma_active(dma_active),
        .timeout_err(timeout_err),
        .err_clr(err_clr)
    );

    always #5 c200m = ~c200m;

    typedef struct {
        logic br;
        logic bgack;
        logic txn;
        logic hold;
        logic bg;
        logic rel;
        logic dma;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b want=%b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic hold, input logic bg,
                              input logic rel, input logic dma, input logic err);
        check({tag, ".txn_hold"}, txn_hold, hold);
        check({tag, ".bg_n"}, bg_n, bg);
        check({tag, ".bus_release"}, bus_release, rel);
        check({tag, ".dma_active"}, dma_active, dma);
        check({tag, ".timeout_err"}, timeout_err, err);
    endtask

    // One full m68k_clk period ending in exactly one falling edge
    task automatic c7m_step(input logic br, input logic bgack, input logic txn);
        @(negedge c200m);
        br_n = br;
        bgack_n = bgack;
        txn_active = txn;
        m68k_clk = 1'b1;
        repeat (8) @(negedge c200m);
        m68k_clk = 1'b0;
        repeat (8) @(negedge c200m);
    endtask

    initial begin
        // br bgack txn | hold bg rel dma
        vecs.push_back('{1, 1, 0, 0, 1, 0, 0});  // 0 idle stays idle
        vecs.push_back('{0, 1, 0, 1, 1, 0, 0});  // 1 br -> drain
        vecs.push_back('{0, 1, 0, 1, 1, 0, 0});  // 2 idle edge 1
        vecs.push_back('{0, 1, 0, 1, 0, 1, 0});  // 3 idle edge 2 -> grant
        vecs.push_back('{0, 0, 0, 1, 1, 1, 1});  // 4 bgack -> owned
        vecs.push_back('{1, 0, 0, 1, 1, 1, 1});  // 5 br released, still owned
        vecs.push_back('{1, 1, 0, 1, 1, 1, 0});  // 6 bgack released -> recover
        vecs.push_back('{1, 1, 0, 0, 1, 0, 0});  // 7 recover -> idle
        vecs.push_back('{0, 1, 1, 1, 1, 0, 0});  // 8 drain with sequencer busy
        vecs.push_back('{0, 1, 1, 1, 1, 0, 0});  // 9
        vecs.push_back('{0, 1, 1, 1, 1, 0, 0});  // 10
        vecs.push_back('{0, 1, 1, 1, 1, 0, 0});  // 11
        vecs.push_back('{0, 1, 1, 1, 1, 0, 0});  // 12 fifth busy edge
        vecs.push_back('{0, 1, 0, 1, 1, 0, 0});  // 13 first idle edge
        vecs.push_back('{0, 1, 0, 1, 0, 1, 0});  // 14 second idle edge -> grant
        vecs.push_back('{1, 1, 0, 0, 1, 0, 0});  // 15 withdrawn in grant -> idle
        vecs.push_back('{0, 1, 0, 1, 1, 0, 0});  // 16 drain
        vecs.push_back('{1, 1, 0, 0, 1, 0, 0});  // 17 withdrawn in drain -> idle
        vecs.push_back('{0, 1, 0, 1, 1, 0, 0});  // 18 drain
        vecs.push_back('{0, 1, 0, 1, 1, 0, 0});  // 19
        vecs.push_back('{0, 1, 0, 1, 0, 1, 0});  // 20 grant
        vecs.push_back('{0, 0, 0, 1, 1, 1, 1});  // 21 owned
        vecs.push_back('{0, 1, 0, 1, 1, 1, 0});  // 22 recover with br still low
        vecs.push_back('{0, 1, 0, 1, 0, 1, 0});  // 23 straight back to grant
        vecs.push_back('{1, 0, 0, 1, 1, 1, 1});  // 24 bgack wins over withdrawal
        vecs.push_back('{1, 1, 0, 1, 1, 1, 0});  // 25 recover
        vecs.push_back('{1, 1, 0, 0, 1, 0, 0});  // 26 idle
        vecs.push_back('{0, 1, 0, 1, 1, 0, 0});  // 27 drain
        vecs.push_back('{0, 1, 0, 1, 1, 0, 0});  // 28 idle edge 1
        vecs.push_back('{0, 1, 1, 1, 1, 0, 0});  // 29 busy edge restarts count
        vecs.push_back('{0, 1, 0, 1, 1, 0, 0});  // 30 idle edge 1
        vecs.push_back('{0, 1, 0, 1, 0, 1, 0});  // 31 idle edge 2 -> grant
        vecs.push_back('{0, 0, 0, 1, 1, 1, 1});  // 32 owned

        repeat (4) @(negedge c200m);
        check_outs("reset", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        repeat (2) @(negedge c200m);

        for (int i = 0; i < vecs.size(); i++) begin
            c7m_step(vecs[i].br, vecs[i].bgack, vecs[i].txn);
            check_outs($sformatf("vec%0d", i), vecs[i].hold, vecs[i].bg,
                       vecs[i].rel, vecs[i].dma, 1'b0);
            if (vecs[i].txn && !bg_n) begin
                errors++;
                $display("FAIL grant_overlap vec%0d bg_n=%b txn_active=1", i, bg_n);
            end
        end

        // Asynchronous reset while owned, master keeps bgack asserted
        @(negedge c200m);
        br_n = 1'b1;
        bgack_n = 1'b0;
        #1 reset_n = 1'b0;
        #1 check_outs("async_rst", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge c200m);
        reset_n = 1'b1;
        c7m_step(1'b1, 1'b0, 1'b0);
        check_outs("post_rst1", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        c7m_step(1'b1, 1'b0, 1'b0);
        check_outs("post_rst2", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Stopped m68k_clk freezes the arbiter
        @(negedge c200m);
        br_n = 1'b0;
        bgack_n = 1'b1;
        repeat (40) @(negedge c200m);
        check("frozen.txn_hold", txn_hold, 1'b0);
        c7m_step(1'b0, 1'b1, 1'b0);
        check("resume.txn_hold", txn_hold, 1'b1);

`ifdef ARB_TIMEOUT_EN
        c7m_step(1'b0, 1'b1, 1'b0);
        c7m_step(1'b0, 1'b1, 1'b0);
        check_outs("tmo_grant", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int e = 1; e < 16; e++) begin
            c7m_step(1'b0, 1'b1, 1'b0);
            check($sformatf("tmo_wait%0d.bg_n", e), bg_n, 1'b0);
        end
        c7m_step(1'b0, 1'b1, 1'b0);
        check_outs("tmo_fire", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        @(negedge c200m);
        err_clr = 1'b1;
        @(negedge c200m);
        err_clr = 1'b0;
        check("tmo_clr.timeout_err", timeout_err, 1'b0);
        c7m_step(1'b0, 1'b1, 1'b0);
        check_outs("tmo_redrain", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        c7m_step(1'b0, 1'b1, 1'b0);
        c7m_step(1'b0, 1'b1, 1'b0);
        check_outs("tmo_regrant", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
`endif

        c7m_step(1'b1, 1'b1, 1'b0);
        check_outs("final_idle", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/m68k_bus_arbiter.md
Name: m68k_bus_arbiter

Overview:
- Arbitrates the Amiga 68000 bus between the PiStorm transaction sequencer and external DMA masters using the BR_n/BG_n/BGACK_n three-wire protocol.
- Runs in the 200 MHz Pi clock domain and detects 7 MHz M68K_CLK edges internally.
- Holds off new sequencer transactions and lets any in-flight transaction complete before granting.
- While a DMA master owns the bus, it tells the datapath to tristate the address, data and strobe drivers.

Parameters:
SYNC_STAGES, 3, flop depth of the synchronisers on m68k_clk, br_n and bgack_n (minimum 2).
GRANT_TIMEOUT, 16, number of c7m falling edges to wait for BGACK before the grant is withdrawn (used only with the optional feature).
DRAIN_IDLE_EDGES, 2, number of consecutive c7m falling edges with txn_active=0 required before BG is asserted.

Ports:
c200m  input  1  200 MHz system clock; the only clock in the block.
reset_n  input  1  asynchronous active-low reset.
m68k_clk  input  1  raw 7 MHz CPU-bus clock; synchronised internally.
br_n  input  1  raw bus request from the Amiga side.
bgack_n  input  1  raw bus grant acknowledge.
txn_active  input  1  high while the sequencer is outside its idle state or has a request pending.
txn_hold  output  1  blocks the sequencer from starting a new transaction.
bg_n  output  1  bus grant to the Amiga side.
bus_release  output  1  tristates the latch OEs, AS_n/UDS_n/LDS_n/RW and FC.
dma_active  output  1  status bit: an external master owns the bus.
timeout_err  output  1  sticky flag: BGACK was not seen in time.
err_clr  input  1  one-cycle pulse that clears timeout_err.

Behaviour:
- Reset values: txn_hold=0, bg_n=1, bus_release=0, dma_active=0, timeout_err=0, state=IDLE, all counters=0.
- Synchroniser reset values: br_n and bgack_n stages reset to 1, m68k_clk stages to 0.
- Edge detect: c7m_fall asserts when the last two synchroniser stages are 1 then 0.
- Sampling: all state transitions, and all br_n/bgack_n/txn_active sampling, occur only in c200m cycles where c7m_fall=1.
- Outputs are registered and change in the same c200m cycle as the state register.
- IDLE: if br_n is low, go to DRAIN and set txn_hold=1. Otherwise no change.
- DRAIN:
  - idle_cnt increments on each c7m_fall with txn_active=0 and resets to 0 when txn_active=1.
  - Once idle_cnt reaches DRAIN_IDLE_EDGES, go to GRANT: bg_n=0, bus_release=1.
  - If br_n goes high first, return to IDLE and set txn_hold=0.
  - The two-edge rule covers a sequencer request launched in the same c7m edge as BR.
- GRANT:
  - bgack_n low: go to OWNED, bg_n=1, dma_active=1.
  - br_n high and bgack_n high (request withdrawn): go to IDLE, bg_n=1, bus_release=0, txn_hold=0.
  - If both conditions hold on the same edge, bgack_n low wins.
- OWNED: txn_hold=1, bus_release=1, dma_active=1. When bgack_n goes high, go to RECOVER and set dma_active=0.
- RECOVER: lasts exactly one c7m_fall with bus_release still 1, guaranteeing one bus cycle of turnaround. At that edge:
  - br_n low: go straight to GRANT (bg_n=0; DRAIN is skipped because the sequencer is still held).
  - Otherwise: go to IDLE with bus_release=0 and txn_hold=0.
- The sequencer is never pre-empted; bg_n is never 0 while txn_active=1 has been seen within the last DRAIN_IDLE_EDGES edges.
- Asserting reset_n low in any state immediately forces the reset values. Any DMA master still holding bgack_n is re-arbitrated from IDLE.
- If m68k_clk stops, the state is frozen.
- err_clr has priority over a simultaneous timeout set.

Optional Feature:
ARB_TIMEOUT_EN
- Defined:
  - In GRANT, an 8-bit tmo_cnt counts c7m_fall edges.
  - When it reaches GRANT_TIMEOUT with bgack_n still high (br_n still low), go to IDLE: bg_n=1, bus_release=0, txn_hold=0, timeout_err=1.
  - The same br_n low then re-enters DRAIN on the next c7m_fall.
  - tmo_cnt clears on entry to GRANT.
- Undefined: no counter; GRANT waits indefinitely; timeout_err is tied to 0.

Test Plan:
- Idle bus, txn_active=0, br_n low at c7m_fall N: expect txn_hold=1 at N, bg_n=0 at N+2 (DEFAULT DRAIN), bus_release=1.
- txn_active high for 5 c7m edges when br_n falls: bg_n stays 1 until 2 edges after txn_active drops; no bg_n=0 overlapping txn_active.
- Grant given, bgack_n low, then br_n high: bg_n returns to 1 at that edge; dma_active=1. bgack_n high for 1 edge: dma_active=0, then bus_release=0 and txn_hold=0 one edge later.
- br_n withdrawn in GRANT before bgack_n: back to IDLE in one edge, bg_n=1, txn_hold=0, timeout_err=0.
- ARB_TIMEOUT_EN, GRANT_TIMEOUT=16, br_n low, bgack_n never asserted: at the 16th edge bg_n=1 and timeout_err=1; err_clr pulse clears it; re-grant follows.
- reset_n pulsed low during OWNED: all outputs take reset values asynchronously. After release with bgack_n still low and br_n high, the block stays IDLE.
